// File: rtl/count_monitor_if.sv
// Bundle between a free-running up-counter and its passive sequence monitor.
// The master side drives the sampled counter bus and controls. The slave side is the monitor.
interface count_monitor_if #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
) ();
    logic [WIDTH-1:0] count_in;
    logic             dut_reset;
    logic             clear;
    logic             locked;
    logic             mismatch;
    logic             wrap;
    logic [ERR_W-1:0] err_count;
    logic [ERR_W-1:0] wrap_count;
    logic [WIDTH-1:0] expected;

    modport master (
        output count_in, dut_reset, clear,
        input  locked, mismatch, wrap, err_count, wrap_count, expected
    );

    modport slave (
        input  count_in, dut_reset, clear,
        output locked, mismatch, wrap, err_count, wrap_count, expected
    );
endinterface

// File: rtl/count_monitor.sv
// Passive monitor for an up-counter. It locks after LOCK_N correct increments, then flags
// every departure from prev+1 and keeps saturating error and wrap statistics.
module count_monitor #(
    parameter int WIDTH  = 4,
    parameter int LOCK_N = 2,
    parameter int ERR_W  = 8
) (
    input  logic           clk,
    input  logic           rst,
    count_monitor_if.slave mon
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ACQUIRE = 2'd1, TRACK = 2'd2} state_e;

    localparam logic [4:0]       LOCK_V  = 5'(LOCK_N);
    localparam logic [ERR_W-1:0] CNT_MAX = {ERR_W{1'b1}};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [3:0]       streak_q, streak_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [ERR_W-1:0] wrapc_q, wrapc_d;
    logic             mismatch_q, mismatch_d;
    logic             wrap_q, wrap_d;

    logic [WIDTH-1:0] next_val;
    logic [4:0]       streak_inc;
    logic             correct;

    assign next_val   = prev_q + WIDTH'(1);
    assign streak_inc = {1'b0, streak_q} + 5'd1;
    assign correct    = (mon.count_in == next_val);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            prev_q     <= '0;
            streak_q   <= '0;
            err_q      <= '0;
            wrapc_q    <= '0;
            mismatch_q <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            streak_q   <= streak_d;
            err_q      <= err_d;
            wrapc_q    <= wrapc_d;
            mismatch_q <= mismatch_d;
            wrap_q     <= wrap_d;
        end
    end

    // prev always follows the bus. While the counter is in reset, the state is frozen and nothing is compared.
    always_comb begin
        state_d    = state_q;
        prev_d     = mon.count_in;
        streak_d   = streak_q;
        mismatch_d = 1'b0;
        wrap_d     = 1'b0;
        if (!mon.dut_reset) begin
            case (state_q)
                EMPTY: begin
                    state_d  = ACQUIRE;
                    streak_d = '0;
                end
                ACQUIRE: begin
                    if (correct) begin
                        if (streak_inc == LOCK_V) begin
                            state_d  = TRACK;
                            streak_d = '0;
                        end else begin
                            streak_d = streak_inc[3:0];
                        end
                    end else begin
                        streak_d = '0;
                    end
                end
                TRACK: begin
                    if (correct) begin
                        wrap_d = &prev_q;
                    end else begin
                        mismatch_d = 1'b1;
                        state_d    = ACQUIRE;
                        streak_d   = '0;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end

        // clear takes priority over a coincident increment
        if (mon.clear)                          err_d = '0;
        else if (mismatch_d && err_q != CNT_MAX) err_d = err_q + ERR_W'(1);
        else                                    err_d = err_q;

        if (mon.clear)                         wrapc_d = '0;
        else if (wrap_d && wrapc_q != CNT_MAX) wrapc_d = wrapc_q + ERR_W'(1);
        else                                   wrapc_d = wrapc_q;
    end

    always_comb begin
        mon.locked     = (state_q == TRACK);
        mon.mismatch   = mismatch_q;
        mon.wrap       = wrap_q;
        mon.err_count  = err_q;
        mon.wrap_count = wrapc_q;
        mon.expected   = next_val;
    end
endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor. It uses WIDTH=4, LOCK_N=2 and ERR_W=2, so saturation is reached quickly.
module tb_count_monitor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    count_monitor_if #(.WIDTH(4), .ERR_W(2)) bus ();

    count_monitor #(.WIDTH(4), .LOCK_N(2), .ERR_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .mon (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [3:0] v, input logic dr = 1'b0, input logic clr = 1'b0);
        @(negedge clk);
        bus.count_in  = v;
        bus.dut_reset = dr;
        bus.clear     = clr;
        @(posedge clk);
        #1;
        $display("[TB] t=%0t in=%0d dr=%0b clr=%0b -> locked=%0b mis=%0b wrap=%0b err=%0d wrapc=%0d exp=%0d",
                 $time, v, dr, clr, bus.locked, bus.mismatch, bus.wrap, bus.err_count,
                 bus.wrap_count, bus.expected);
    endtask

    initial begin
        logic [3:0] p;
        logic [3:0] g;
        bus.count_in  = '0;
        bus.dut_reset = 1'b0;
        bus.clear     = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_locked", bus.locked, 0);
        check("rst_mismatch", bus.mismatch, 0);
        check("rst_err", bus.err_count, 0);
        check("rst_wrapc", bus.wrap_count, 0);
        check("rst_expected", bus.expected, 1);
        @(negedge clk);
        rst = 1'b0;

        // Lock-on: locked is expected to rise after the third sampling edge
        step(4'd0); check("lock_e1", bus.locked, 0);
        step(4'd1); check("lock_e2", bus.locked, 0);
        step(4'd2); check("lock_e3", bus.locked, 1);
        check("lock_mis", bus.mismatch, 0);
        check("lock_exp", bus.expected, 3);
        step(4'd3); check("lock_e4", bus.locked, 1);
        check("lock_err", bus.err_count, 0);

        // Run up to the wrap point
        for (int v = 4; v <= 13; v++) begin
            step(4'(v));
            check("run_mis", bus.mismatch, 0);
            check("run_wrap", bus.wrap, 0);
        end
        step(4'd14); check("wrap_14", bus.wrap, 0);
        step(4'd15); check("wrap_15", bus.wrap, 0);
        step(4'd0);  check("wrap_0_pulse", bus.wrap, 1);
        check("wrap_0_cnt", bus.wrap_count, 1);
        step(4'd1);  check("wrap_1_pulse", bus.wrap, 0);
        check("wrap_1_cnt", bus.wrap_count, 1);
        check("wrap_err", bus.err_count, 0);

        // Glitch 6 -> 9
        for (int v = 2; v <= 6; v++) step(4'(v));
        check("glitch_pre_locked", bus.locked, 1);
        step(4'd9);
        check("glitch_mis", bus.mismatch, 1);
        check("glitch_err", bus.err_count, 1);
        check("glitch_locked", bus.locked, 0);
        step(4'd10);
        check("glitch_mis_gone", bus.mismatch, 0);
        check("glitch_acq", bus.locked, 0);
        step(4'd11);
        check("glitch_relock", bus.locked, 1);

        // Count to 7 through a second wrap
        for (int v = 12; v <= 15; v++) step(4'(v));
        step(4'd0);
        check("wrap2_cnt", bus.wrap_count, 2);
        for (int v = 1; v <= 7; v++) step(4'(v));
        check("at7_locked", bus.locked, 1);

        // The monitored counter is reset for 2 edges
        step(4'd0, 1'b1);
        check("dr1_mis", bus.mismatch, 0);
        check("dr1_locked", bus.locked, 1);
        step(4'd0, 1'b1);
        check("dr2_mis", bus.mismatch, 0);
        check("dr2_exp", bus.expected, 1);
        step(4'd1);
        check("dr_rel1_mis", bus.mismatch, 0);
        step(4'd2);
        check("dr_rel2_mis", bus.mismatch, 0);
        check("dr_locked", bus.locked, 1);
        check("dr_err", bus.err_count, 1);

        // Clear on a correct sample
        step(4'd3, 1'b0, 1'b1);
        check("clr_err", bus.err_count, 0);
        check("clr_wrapc", bus.wrap_count, 0);
        check("clr_locked", bus.locked, 1);

        // Saturation: 5 mismatches, each followed by a relock
        p = 4'd3;
        for (int i = 1; i <= 5; i++) begin
            g = p + 4'd5;
            step(g);
            check("sat_mis", bus.mismatch, 1);
            check("sat_err", bus.err_count, (i > 3) ? 3 : i);
            step(g + 4'd1);
            step(g + 4'd2);
            check("sat_relock", bus.locked, 1);
            p = g + 4'd2;
        end
        // A mismatch with a coincident clear
        g = p + 4'd5;
        step(g, 1'b0, 1'b1);
        check("satclr_mis", bus.mismatch, 1);
        check("satclr_err", bus.err_count, 0);
        check("satclr_wrapc", bus.wrap_count, 0);
        step(g + 4'd1);
        step(g + 4'd2);
        p = g + 4'd2;
        check("hold_pre_locked", bus.locked, 1);

        // A held value counts as a mismatch
        step(p);
        check("hold_mis", bus.mismatch, 1);
        check("hold_err", bus.err_count, 1);
        step(p + 4'd1);
        step(p + 4'd2);
        check("async_pre_locked", bus.locked, 1);

        // Asynchronous reset between edges
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_locked", bus.locked, 0);
        check("arst_err", bus.err_count, 0);
        check("arst_wrapc", bus.wrap_count, 0);
        check("arst_exp_m1", int'(bus.expected - 4'd1), 0);
        @(negedge clk);
        rst = 1'b0;
        step(4'd5);
        check("post_arst_locked", bus.locked, 0);
        check("post_arst_exp", bus.expected, 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
